// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_EQ   = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_MUL  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    localparam logic [3:0] OP_MUL        = 4'd11;
    localparam logic [3:0] OP_LAST_LEGAL = 4'd11;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, low DATA_WIDTH bits of the product.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] opa,
    input  logic [DATA_WIDTH-1:0] opb,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [CW-1:0]         cnt;
    logic                  busy;

    // The final partial product is folded in combinationally so the result is ready on the last busy cycle.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign done     = busy && (cnt == '0);
    assign product  = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= opa;
            mplier <= opb;
            acc    <= '0;
            cnt    <= CW'(DATA_WIDTH - 1);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            if (cnt == '0) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, registered result and flags.
module alu_mc
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            aluctrl,
    input  logic [DATA_WIDTH-1:0] aluop1,
    input  logic [DATA_WIDTH-1:0] aluop2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] aluout,
    output logic                  eq,
    output logic                  zero,
    output logic                  neg,
    output logic                  carry,
    output logic                  ovf,
    output logic                  err
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int MSB = DATA_WIDTH - 1;

    alu_state_e state, state_nx;

    logic                         accept;
    logic                         op_is_mul;
    logic                         op_legal;
    logic                         mul_done;
    logic                         mul_eq;
    logic [DATA_WIDTH-1:0]        mul_product;
    logic [DATA_WIDTH:0]          add_w;
    logic [DATA_WIDTH:0]          sub_w;
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    logic [SHW-1:0]               shamt;
    logic [DATA_WIDTH-1:0]        res_c;
    logic                         carry_c;
    logic                         ovf_c;

    assign op_is_mul = (MUL_EN != 0) && (aluctrl == OP_MUL);
    assign op_legal  = (aluctrl <= OP_LAST_LEGAL) && ((aluctrl != OP_MUL) || (MUL_EN != 0));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // In DONE the consumer's ready doubles as our ready, allowing retire and accept on the same edge.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = op_is_mul ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_nx = op_is_mul ? BUSY : DONE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Subtraction as A + ~B + 1 so the top bit reads directly as no-borrow.
    assign add_w = {1'b0, aluop1} + {1'b0, aluop2};
    assign sub_w = {1'b0, aluop1} + {1'b0, ~aluop2} + 1'b1;
    assign sa    = aluop1;
    assign sb    = aluop2;
    assign shamt = aluop2[SHW-1:0];

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (aluctrl)
            ALU_ADD: begin
                res_c   = add_w[MSB:0];
                carry_c = add_w[DATA_WIDTH];
                ovf_c   = (aluop1[MSB] == aluop2[MSB]) && (add_w[MSB] != aluop1[MSB]);
            end
            ALU_SUB: begin
                res_c   = sub_w[MSB:0];
                carry_c = sub_w[DATA_WIDTH];
                ovf_c   = (aluop1[MSB] != aluop2[MSB]) && (sub_w[MSB] != aluop1[MSB]);
            end
            ALU_AND:  res_c = aluop1 & aluop2;
            ALU_OR:   res_c = aluop1 | aluop2;
            ALU_XOR:  res_c = aluop1 ^ aluop2;
            ALU_SLT:  res_c = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
            ALU_SLTU: res_c = {{(DATA_WIDTH-1){1'b0}}, (aluop1 < aluop2)};
            ALU_SLL:  res_c = aluop1 << shamt;
            ALU_SRL:  res_c = aluop1 >> shamt;
            ALU_SRA:  res_c = sa >>> shamt;
            default:  res_c = '0;
        endcase
    end

    // Result and flags load only on the edge that enters DONE; MUL keeps its eq flag until then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluout <= '0;
            eq     <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            mul_eq <= 1'b0;
        end else if (accept && !op_is_mul) begin
            aluout <= res_c;
            eq     <= op_legal && (aluop1 == aluop2);
            zero   <= op_legal && (res_c == '0);
            neg    <= res_c[MSB];
            carry  <= carry_c;
            ovf    <= ovf_c;
            err    <= !op_legal;
        end else if (accept) begin
            mul_eq <= (aluop1 == aluop2);
        end else if ((state == BUSY) && mul_done) begin
            aluout <= mul_product;
            eq     <= mul_eq;
            zero   <= (mul_product == '0);
            neg    <= mul_product[MSB];
            carry  <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end
    end

    if (MUL_EN != 0) begin : g_mul
        alu_mul_iter #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_mul (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (accept && op_is_mul),
            .opa    (aluop1),
            .opb    (aluop2),
            .done   (mul_done),
            .product(mul_product)
        );
    end else begin : g_nomul
        assign mul_done    = 1'b0;
        assign mul_product = '0;
    end

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc against a plain-arithmetic reference model.
module tb_alu_mc;

    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] res;
        logic        eq;
        logic        zero;
        logic        neg;
        logic        carry;
        logic        ovf;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  aluctrl;
    logic [31:0] aluop1, aluop2, aluout;
    logic        eq, zero, neg, carry, ovf, err;

    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [3:0]  n_aluctrl;
    logic [31:0] n_aluop1, n_aluop2, n_aluout;
    logic        n_eq, n_zero, n_neg, n_carry, n_ovf, n_err;

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    alu_mc #(.DATA_WIDTH(DW), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluctrl(aluctrl), .aluop1(aluop1), .aluop2(aluop2),
        .out_valid(out_valid), .out_ready(out_ready), .aluout(aluout),
        .eq(eq), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .err(err)
    );

    alu_mc #(.DATA_WIDTH(DW), .MUL_EN(0)) dut_nomul (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .aluctrl(n_aluctrl), .aluop1(n_aluop1), .aluop2(n_aluop2),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .aluout(n_aluout),
        .eq(n_eq), .zero(n_zero), .neg(n_neg), .carry(n_carry), .ovf(n_ovf), .err(n_err)
    );

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input bit mul_en);
        exp_t        e;
        longint      sa, sb, s;
        logic [63:0] w;
        int          r32;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: begin
                w = 64'(a) + 64'(b);
                e.res = w[31:0];
                e.carry = w[32];
                s = sa + sb;
                r32 = e.res;
                e.ovf = (s != longint'(r32));
            end
            4'd1: e.res = 32'd0;
            4'd2: begin
                e.res = a - b;
                e.carry = (a >= b);
                s = sa - sb;
                r32 = e.res;
                e.ovf = (s != longint'(r32));
            end
            4'd3: e.res = a & b;
            4'd4: e.res = a | b;
            4'd5: e.res = a ^ b;
            4'd6: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: e.res = (a < b) ? 32'd1 : 32'd0;
            4'd8: e.res = a << b[4:0];
            4'd9: e.res = a >> b[4:0];
            4'd10: begin
                s = sa >>> b[4:0];
                e.res = s[31:0];
            end
            4'd11: begin
                if (mul_en) begin
                    w = 64'(a) * 64'(b);
                    e.res = w[31:0];
                end else begin
                    e.err = 1'b1;
                end
            end
            default: e.err = 1'b1;
        endcase
        if (!e.err) begin
            e.eq   = (a == b);
            e.zero = (e.res == 32'd0);
            e.neg  = e.res[31];
        end
        return e;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        exp_t e;
        int   lat, guard, exp_lat;
        logic busy_ok;
        e = model(op, a, b, 1'b1);
        exp_lat = (op == 4'd11) ? DW : 0;
        in_valid = 1'b1; aluctrl = op; aluop1 = a; aluop2 = b;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL %s in_ready timeout: got %b want 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; aluctrl = 4'($urandom); aluop1 = $urandom; aluop2 = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges want %0d", name, lat, exp_lat);
        end
        if (op == 4'd11) begin
            n_checks++;
            if (!busy_ok) begin
                n_fail++;
                $display("FAIL %s in_ready during BUSY: got 1 want 0", name);
            end
        end
        n_checks++;
        if (aluout !== e.res) begin
            n_fail++;
            $display("FAIL %s aluout: got %h want %h", name, aluout, e.res);
        end
        n_checks++;
        if ({eq, zero, neg, carry, ovf, err} !== {e.eq, e.zero, e.neg, e.carry, e.ovf, e.err}) begin
            n_fail++;
            $display("FAIL %s flags eq/zero/neg/carry/ovf/err: got %b want %b", name,
                     {eq, zero, neg, carry, ovf, err}, {e.eq, e.zero, e.neg, e.carry, e.ovf, e.err});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s retire: out_valid got %b want 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, aluout, eq, zero, neg, carry, ovf, err} !== {1'b1, 1'b0, 32'd0, 6'd0}) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b aluout=%h flags=%b want 1 0 0 0",
                     in_ready, out_valid, aluout, {eq, zero, neg, carry, ovf, err});
        end
        n_checks++;
        if ({n_in_ready, n_out_valid, n_aluout} !== {1'b1, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_nomul: in_ready=%b out_valid=%b aluout=%h want 1 0 0",
                     n_in_ready, n_out_valid, n_aluout);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [3:0]  ops [13] = '{4'd0, 4'd0, 4'd2, 4'd1, 4'd10, 4'd6, 4'd11, 4'd13,
                                  4'd7, 4'd8, 4'd9, 4'd2, 4'd15};
        logic [31:0] as  [13] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd3, 32'd7, 32'h80000000,
                                  32'hFFFFFFFF, 32'h12345678, 32'h5, 32'hFFFFFFFF, 32'h1,
                                  32'h80000000, 32'h80000000, 32'h0};
        logic [31:0] bs  [13] = '{32'h1, 32'h1, 32'd5, 32'd7, 32'd36, 32'h1, 32'h10, 32'h5,
                                  32'h1, 32'd31, 32'd63, 32'h1, 32'h0};
        for (int i = 0; i < 13; i++) begin
            run_op(ops[i], as[i], bs[i], $sformatf("directed%0d", i));
        end
    endtask

    task automatic test_stall();
        exp_t        e;
        logic [31:0] a, b, snap_out;
        logic [5:0]  snap_flags;
        int          guard;
        a = $urandom; b = $urandom;
        e = model(4'd2, a, b, 1'b1);
        in_valid = 1'b1; aluctrl = 4'd2; aluop1 = a; aluop2 = b;
        @(posedge clk); #1;
        aluctrl = 4'd0; aluop1 = $urandom; aluop2 = $urandom;
        guard = 0;
        while (!out_valid && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        snap_out = aluout;
        snap_flags = {eq, zero, neg, carry, ovf, err};
        n_checks++;
        if (snap_out !== e.res) begin
            n_fail++;
            $display("FAIL stall result: got %h want %h", snap_out, e.res);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || aluout !== snap_out ||
                {eq, zero, neg, carry, ovf, err} !== snap_flags) begin
                n_fail++;
                $display("FAIL stall hold %0d: valid=%b ready=%b aluout=%h flags=%b want 1 0 %h %b",
                         i, out_valid, in_ready, aluout, {eq, zero, neg, carry, ovf, err},
                         snap_out, snap_flags);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall retire: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        q[$];
        exp_t        e;
        logic [31:0] a, b;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            q.push_back(model(4'd0, a, b, 1'b1));
            in_valid = 1'b1; aluctrl = 4'd0; aluop1 = a; aluop2 = b;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b%0d in_ready: got %b want 1", i, in_ready);
            end
            @(posedge clk); #1;
            e = q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || aluout !== e.res || carry !== e.carry) begin
                n_fail++;
                $display("FAIL b2b%0d: valid=%b aluout=%h carry=%b want 1 %h %b",
                         i, out_valid, aluout, carry, e.res, e.carry);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            run_op(op, $urandom, $urandom, $sformatf("rand%0d_op%0d", i, op));
        end
    endtask

    task automatic test_mul_en0();
        logic [3:0]  ops [2] = '{4'd11, 4'd0};
        exp_t        e;
        logic [31:0] a, b;
        for (int i = 0; i < 2; i++) begin
            a = $urandom; b = $urandom;
            e = model(ops[i], a, b, 1'b0);
            n_in_valid = 1'b1; n_aluctrl = ops[i]; n_aluop1 = a; n_aluop2 = b;
            @(posedge clk); #1;
            n_in_valid = 1'b0;
            n_checks++;
            if (n_out_valid !== 1'b1 || n_aluout !== e.res ||
                {n_eq, n_zero, n_neg, n_carry, n_ovf, n_err} !== {e.eq, e.zero, e.neg, e.carry, e.ovf, e.err}) begin
                n_fail++;
                $display("FAIL nomul op%0d: valid=%b aluout=%h flags=%b want 1 %h %b", ops[i],
                         n_out_valid, n_aluout, {n_eq, n_zero, n_neg, n_carry, n_ovf, n_err},
                         e.res, {e.eq, e.zero, e.neg, e.carry, e.ovf, e.err});
            end
            n_out_ready = 1'b1;
            @(posedge clk); #1;
            n_out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_busy();
        logic stale;
        in_valid = 1'b1; aluctrl = 4'd11; aluop1 = $urandom | 32'h1; aluop2 = $urandom | 32'h1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid-mul busy: in_ready got %b want 0", in_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || aluout !== 32'd0) begin
            n_fail++;
            $display("FAIL async reset mid-mul: valid=%b ready=%b aluout=%h want 0 1 0",
                     out_valid, in_ready, aluout);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        n_checks++;
        if (stale) begin
            n_fail++;
            $display("FAIL stale mul retire after reset: out_valid got 1 want 0");
        end
        in_valid = 1'b1; aluctrl = 4'd0; aluop1 = 32'd2; aluop2 = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || aluout !== 32'd4) begin
            n_fail++;
            $display("FAIL post-reset add: valid=%b aluout=%h want 1 00000004", out_valid, aluout);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        in_valid = 1'b0; out_ready = 1'b0; aluctrl = 4'd0; aluop1 = '0; aluop2 = '0;
        n_in_valid = 1'b0; n_out_ready = 1'b0; n_aluctrl = 4'd0; n_aluop1 = '0; n_aluop2 = '0;
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_random();
        test_mul_en0();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
